// File: rtl/bit_noc_pkg.sv
// Shared constants and helpers for the bit-level NoC gather/select stages.
package bit_noc_pkg;

  localparam int IN_DATA_WIDTH  = 4;
  localparam int OUT_DATA_WIDTH = 8;

  // Padding bit replicated into unfilled slices of a flushed word.
  localparam logic PAD_BIT = 1'b0;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int calc_cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/bit_pack_skid_reg.sv
// Output register plus one-word stash giving a valid/ready interface that
// never exposes a combinational path from i_ready to the upstream ready.
module bit_pack_skid_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  stash_full
);

  logic [DATA_WIDTH-1:0] stash;
  logic                  out_free;

  assign out_free = !o_valid || i_ready;

  // A full stash always drains first; upstream is stalled meanwhile, so a
  // load never arrives while the stash is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      stash      <= '0;
      stash_full <= 1'b0;
    end else if (stash_full && out_free) begin
      o_valid    <= 1'b1;
      o_data_bus <= stash;
      stash      <= '0;
      stash_full <= 1'b0;
    end else if (load_valid) begin
      if (out_free) begin
        o_valid    <= 1'b1;
        o_data_bus <= load_data;
      end else begin
        stash      <= load_data;
        stash_full <= 1'b1;
      end
    end else if (out_free) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_pack_4x8_seq.sv
// Gathers narrow slices (first slice in LSBs) into wide words with zero-padded flush.
// Define BIT_PACK_OVERFLOW_DET_EN to build the sticky o_overflow detector.
module bit_pack_4x8_seq #(
  parameter int IN_DATA_WIDTH  = bit_noc_pkg::IN_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = bit_noc_pkg::OUT_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [IN_DATA_WIDTH-1:0]  i_data_bus,
  input  logic                      i_en,
  input  logic                      i_flush,
  output logic                      o_in_ready,
  output logic                      o_valid,
  output logic [OUT_DATA_WIDTH-1:0] o_data_bus,
  input  logic                      i_ready,
  output logic                      o_overflow
);

  import bit_noc_pkg::*;

  localparam int RATIO     = calc_ratio(IN_DATA_WIDTH, OUT_DATA_WIDTH);
  localparam int CNT_WIDTH = calc_cnt_width(RATIO);

  logic [OUT_DATA_WIDTH-1:0] acc;
  logic [OUT_DATA_WIDTH-1:0] word_next;
  logic [CNT_WIDTH-1:0]      cnt;
  logic                      stash_full;
  logic                      accept;
  logic                      flush_only;
  logic                      complete;

  assign o_in_ready = !stash_full;
  assign accept     = i_en && i_valid && o_in_ready;
  assign flush_only = i_en && i_flush && !i_valid && o_in_ready && (cnt != '0);
  assign complete   = (accept && (i_flush || int'(cnt) == RATIO - 1)) || flush_only;

  always_comb begin
    word_next = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && int'(cnt) == i) begin
        word_next[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = i_data_bus;
      end else if (complete && i >= int'(cnt)) begin
        word_next[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] = {IN_DATA_WIDTH{PAD_BIT}};
      end
    end
  end

  // Completed words are handed straight to the skid stage, so the gather
  // register restarts empty and later padding is guaranteed zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (complete) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= word_next;
      cnt <= cnt + 1'b1;
    end
  end

  bit_pack_skid_reg #(
    .DATA_WIDTH(OUT_DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_valid(complete),
    .load_data (word_next),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .stash_full(stash_full)
  );

`ifdef BIT_PACK_OVERFLOW_DET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow <= 1'b0;
    end else if (i_en && i_valid && !o_in_ready) begin
      o_overflow <= 1'b1;
    end
  end
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bit_pack_4x8_seq.sv
// Self-checking bench for bit_pack_4x8_seq: directed table plus randomized
// traffic against a queue-based reference model.
module tb_bit_pack_4x8_seq;

  localparam int IN_W  = 4;
  localparam int OUT_W = 8;
  localparam int RATIO = OUT_W / IN_W;
`ifdef BIT_PACK_OVERFLOW_DET_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic [IN_W-1:0]  i_data_bus;
  logic             i_en;
  logic             i_flush;
  logic             o_in_ready;
  logic             o_valid;
  logic [OUT_W-1:0] o_data_bus;
  logic             i_ready;
  logic             o_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_pack_4x8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_data_bus(i_data_bus),
    .i_en      (i_en),
    .i_flush   (i_flush),
    .o_in_ready(o_in_ready),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .i_ready   (i_ready),
    .o_overflow(o_overflow)
  );

  typedef struct {
    bit             rst;
    bit             en;
    bit             valid;
    bit [IN_W-1:0]  data;
    bit             flush;
    bit             rdy;
    bit             exp_ov;
    bit             chk_od;
    bit [OUT_W-1:0] exp_od;
    bit             exp_ir;
    bit             exp_ovf;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(bit r, bit en, bit v, bit [IN_W-1:0] d, bit fl, bit rdy,
                              bit eov, bit chk, bit [OUT_W-1:0] eod, bit eir, bit eovf);
    vec_t t;
    t.rst = r; t.en = en; t.valid = v; t.data = d; t.flush = fl; t.rdy = rdy;
    t.exp_ov = eov; t.chk_od = chk; t.exp_od = eod; t.exp_ir = eir; t.exp_ovf = eovf;
    return t;
  endfunction

  // Reference model state: words awaiting the output, slices being gathered.
  logic [OUT_W-1:0] outq[$];
  logic [IN_W-1:0]  gath[$];
  bit               m_ovf;

  task automatic applyStimulus(input bit r, input bit en, input bit v,
                               input logic [IN_W-1:0] d, input bit fl, input bit rdy);
    rst = r; i_en = en; i_valid = v; i_data_bus = d; i_flush = fl; i_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [OUT_W-1:0] packSlices();
    logic [OUT_W-1:0] w = '0;
    foreach (gath[k]) w = w | (OUT_W'(gath[k]) << (IN_W * k));
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit ir, acc, fonly, done;
    logic [OUT_W-1:0] w;
    if (rst) begin
      outq.delete(); gath.delete(); m_ovf = 1'b0;
      return;
    end
    ir    = outq.size() < 2;
    acc   = i_en && i_valid && ir;
    fonly = i_en && i_flush && !i_valid && ir && gath.size() > 0;
    done  = 1'b0;
    w     = '0;
    if (i_en && i_valid && !ir && OVF_EN) m_ovf = 1'b1;
    if (acc) gath.push_back(i_data_bus);
    if ((acc && (i_flush || gath.size() == RATIO)) || fonly) begin
      w = packSlices();
      gath.delete();
      done = 1'b1;
    end
    if (outq.size() > 0 && i_ready) void'(outq.pop_front());
    if (done) outq.push_back(w);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    nextCycle();
    nextCycle();
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_data_bus", 32'(o_data_bus), 32'h00);
    checkOutput("reset o_in_ready", 32'(o_in_ready), 32'd1);
    checkOutput("reset o_overflow", 32'(o_overflow), 32'd0);

    // Basic pack, flush, empty flush, backpressure, enable-off, reset mid-op.
    vecs[0]  = mk(0,1,1,4'h8,0,1, 0,0,8'h00,1,0);
    vecs[1]  = mk(0,1,1,4'h6,0,1, 0,0,8'h00,1,0);
    vecs[2]  = mk(0,1,0,4'h0,0,1, 1,1,8'h68,1,0);
    vecs[3]  = mk(0,1,1,4'h5,1,1, 0,0,8'h00,1,0);
    vecs[4]  = mk(0,1,0,4'h0,0,1, 1,1,8'h05,1,0);
    vecs[5]  = mk(0,1,0,4'h0,1,1, 0,0,8'h00,1,0);
    vecs[6]  = mk(0,1,0,4'h0,0,1, 0,0,8'h00,1,0);
    vecs[7]  = mk(0,1,1,4'h1,0,0, 0,0,8'h00,1,0);
    vecs[8]  = mk(0,1,1,4'h2,0,0, 0,0,8'h00,1,0);
    vecs[9]  = mk(0,1,1,4'h3,0,0, 1,1,8'h21,1,0);
    vecs[10] = mk(0,1,1,4'h4,0,0, 1,1,8'h21,1,0);
    vecs[11] = mk(0,1,1,4'hF,0,0, 1,1,8'h21,0,0);
    vecs[12] = mk(0,1,0,4'h0,0,1, 1,1,8'h21,0,1);
    vecs[13] = mk(0,1,0,4'h0,0,1, 1,1,8'h43,1,1);
    vecs[14] = mk(0,1,0,4'h0,0,1, 0,0,8'h00,1,1);
    vecs[15] = mk(0,0,1,4'h7,0,1, 0,0,8'h00,1,1);
    vecs[16] = mk(0,0,1,4'h9,1,1, 0,0,8'h00,1,1);
    vecs[17] = mk(0,1,0,4'h0,1,1, 0,0,8'h00,1,1);
    vecs[18] = mk(0,1,0,4'h0,0,1, 0,0,8'h00,1,1);
    vecs[19] = mk(0,1,1,4'h3,0,1, 0,0,8'h00,1,1);
    vecs[20] = mk(1,1,0,4'h0,0,1, 0,0,8'h00,1,1);
    vecs[21] = mk(0,1,1,4'hA,0,1, 0,0,8'h00,1,0);
    vecs[22] = mk(0,1,1,4'hB,0,1, 0,0,8'h00,1,0);
    vecs[23] = mk(0,1,0,4'h0,0,1, 1,1,8'hBA,1,0);
    vecs[24] = mk(0,1,0,4'h0,0,1, 0,0,8'h00,1,0);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].data,
                    vecs[i].flush, vecs[i].rdy);
      #1;
      checkOutput($sformatf("vec%0d o_valid", i), 32'(o_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk_od)
        checkOutput($sformatf("vec%0d o_data_bus", i), 32'(o_data_bus), 32'(vecs[i].exp_od));
      checkOutput($sformatf("vec%0d o_in_ready", i), 32'(o_in_ready), 32'(vecs[i].exp_ir));
      checkOutput($sformatf("vec%0d o_overflow", i), 32'(o_overflow),
                  32'(vecs[i].exp_ovf & OVF_EN));
      nextCycle();
    end

    // Randomized traffic against the reference model.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    modelEdge();
    nextCycle();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 6),
                    4'($urandom),
                    ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 3) != 0));
      #1;
      checkOutput("rand o_valid", 32'(o_valid), 32'(outq.size() > 0));
      if (outq.size() > 0) checkOutput("rand o_data_bus", 32'(o_data_bus), 32'(outq[0]));
      checkOutput("rand o_in_ready", 32'(o_in_ready), 32'(outq.size() < 2));
      checkOutput("rand o_overflow", 32'(o_overflow), 32'(m_ovf));
      modelEdge();
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_pack_4x8_seq.md
Name: bit_pack_4x8_seq

Overview:
- Downstream neighbour of the 8-to-4 bit-selection stage.
- Gathers consecutive IN_DATA_WIDTH-bit selected slices into one OUT_DATA_WIDTH-bit word, with the first slice in the LSBs.
- Presents each word on a valid/ready output interface backed by a one-word skid stash.
- Supports a flush that zero-pads and emits a partially gathered word, so selected slices can be re-widened for the next NoC hop.

Parameters:
- IN_DATA_WIDTH, 4, width of each incoming slice.
- OUT_DATA_WIDTH, 8, packed word width; must be an integer multiple of IN_DATA_WIDTH, and the multiple must be ≥ 2.
- RATIO, OUT_DATA_WIDTH/IN_DATA_WIDTH (2), slices per word; derived, not overridden.
- CNT_WIDTH, $clog2(RATIO) (1), width of the slice counter; derived.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  slice valid.
- i_data_bus  input  IN_DATA_WIDTH  incoming slice.
- i_en  input  1  enable; when 0, i_valid and i_flush are treated as 0.
- i_flush  input  1  close the current partial word (zero-pad) and emit it.
- o_in_ready  output  1  block can accept a slice this cycle.
- o_valid  output  1  packed word valid.
- o_data_bus  output  OUT_DATA_WIDTH  packed word.
- i_ready  input  1  downstream accepts o_data_bus.
- o_overflow  output  1  sticky: slice presented while o_in_ready=0 (only with optional feature).

Behaviour:
- State: acc (OUT_DATA_WIDTH), cnt (CNT_WIDTH), acc_full (1), out register (o_data_bus, o_valid).
- Reset (rst=1 at a rising edge): o_valid=0, o_data_bus=0, acc=0, cnt=0, acc_full=0, o_overflow=0. This also implies o_in_ready=1.
- Reset mid-operation discards every partial or pending word without emitting it.
- o_in_ready = !acc_full. This is combinational from state only, with no path from i_ready.
- Definitions used below:
  - accept = i_en & i_valid & o_in_ready.
  - out_free = !o_valid | i_ready.
- Accept with cnt < RATIO-1 and no flush: write slice into acc[cnt*IN +: IN], then cnt++.
- Completion occurs on accept with cnt == RATIO-1, or on accept with i_flush (the slice is included, remaining upper slices are 0).
  - If out_free: out register <= completed word, o_valid=1 next cycle.
  - Otherwise: acc holds the word, acc_full=1.
  - In both cases cnt <= 0.
- Flush with no accept (i_en & i_flush & !i_valid & o_in_ready):
  - If cnt > 0: complete the current acc with zero padding, same as above.
  - If cnt == 0: no-op, no empty word is produced.
- Flush while acc_full=1 is ignored; upstream must re-assert it.
- Stash drain: if acc_full & out_free, out register <= acc, acc_full <= 0, acc <= 0.
  - Draining takes priority; no accept can happen that cycle because o_in_ready=0.
- Output handshake:
  - The word leaves on o_valid & i_ready.
  - o_valid clears next cycle unless a new word is loaded in the same cycle (back-to-back words are allowed).
  - o_data_bus is held stable while o_valid & !i_ready.
- Latency: a word is valid on the cycle after its completing slice edge when the output is free.
- Sustained throughput: 1 word per RATIO cycles with i_ready held at 1.
- acc is cleared to 0 after each completion, so padding is always 0.

Optional Feature:
- Macro: BIT_PACK_OVERFLOW_DET_EN.
- Defined: o_overflow is set on any cycle with i_en & i_valid & !o_in_ready. It stays set until rst; the dropped slice is not stored.
- Undefined: o_overflow is tied to 0, no detection logic is built, and the slice is still silently dropped.

Decomposition:
- Shared package bit_noc_pkg holds:
  - the width constants (IN_DATA_WIDTH=4, OUT_DATA_WIDTH=8);
  - a function computing RATIO and CNT_WIDTH;
  - the zero dummy-data constant used as padding.
- One sub-module is natural: bit_pack_skid_reg, the out register plus stash implementing valid/ready with out_free logic.
- The gather counter and slice insertion stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with i_valid=1 -> o_valid=0, o_data_bus=0x00, o_in_ready=1, o_overflow=0.
- Basic pack: slices 0x8 then 0x6 on consecutive cycles, i_ready=1 -> o_data_bus=0x68 with o_valid=1 for one cycle, the cycle after 0x6.
- Flush partial: slice 0x5 with i_flush=1 -> o_data_bus=0x05. A separate i_flush with cnt=0 -> no o_valid.
- Backpressure: i_ready=0, send slices 0x1,0x2,0x3,0x4 ->
  - o_data_bus=0x21 is held;
  - after 0x4, acc_full=1 and o_in_ready=0;
  - raise i_ready -> 0x21, then 0x43 emitted on consecutive cycles.
- Overflow (macro defined): while o_in_ready=0, present slice 0xF -> o_overflow=1 stays set; the next words contain no 0xF. Macro undefined -> o_overflow stays 0.
- Enable and reset mid-op: i_en=0 with slices 0x7,0x9 -> no change. Then slice 0x3 accepted (cnt=1), then rst pulse -> cnt=0, and the next 0xA,0xB produces 0xBA.
